// File: rtl/dpa_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dpa_lane_align
// Purpose  : Per-lane dynamic phase alignment for the RGMII receive path.
//            Sweeps every lane's IDELAY tap against a 1010 training pattern
//            and loads the centre of the longest passing window.
//            Optional macro DPA_RETRAIN_EN adds periodic self-recalibration.
// Revision : 1.0  initial release
// ============================================================================
module dpa_lane_align #(
    parameter int LANES          = 5,
    parameter int TAP_W          = 5,
    parameter int NTAPS          = 32,
    parameter int SETTLE_CYCLES  = 8,
    parameter int CHECK_CYCLES   = 64,
    parameter int MIN_EYE        = 4,
    parameter int RETRAIN_CYCLES = 125000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [LANES-1:0]             rx_sample,
    output logic [LANES*TAP_W-1:0]       tap_out,
    output logic [LANES-1:0]             tap_load,
    output logic                         busy,
    output logic                         done,
    output logic [LANES-1:0]             lane_ok,
    output logic [LANES*(TAP_W+1)-1:0]   eye_width
);

    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LEN_W   = TAP_W + 1;

    localparam logic [TAP_W-1:0]  LAST_TAP    = TAP_W'(NTAPS - 1);
    localparam logic [TAP_W-1:0]  MID_TAP     = TAP_W'(NTAPS / 2);
    localparam logic [LEN_W-1:0]  MIN_LEN     = LEN_W'(MIN_EYE);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CHECK_LAST  = CNT_W'(CHECK_CYCLES);
    localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SET_TAP   = 3'd1,
        S_SETTLE    = 3'd2,
        S_CHECK     = 3'd3,
        S_EVAL      = 3'd4,
        S_CENTER    = 3'd5,
        S_NEXT_LANE = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t                       state_q, state_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    logic [TAP_W-1:0]             tap_q, tap_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         ref_q, ref_d;
    logic                         fail_q, fail_d;
    logic [LEN_W-1:0]             cur_len_q, cur_len_d;
    logic [TAP_W-1:0]             cur_start_q, cur_start_d;
    logic [LEN_W-1:0]             best_len_q, best_len_d;
    logic [TAP_W-1:0]             best_start_q, best_start_d;
    logic [LANES*TAP_W-1:0]       tap_out_q, tap_out_d;
    logic [LANES-1:0]             tap_load_q, tap_load_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [LANES-1:0]             lane_ok_q, lane_ok_d;
    logic [LANES*LEN_W-1:0]       eye_width_q, eye_width_d;

    logic                         rx_bit;
    logic                         auto_start;
    logic                         go;
    logic                         center_ok;
    logic [TAP_W-1:0]             center_tap;

`ifdef DPA_RETRAIN_EN
    localparam int RT_W = $clog2(RETRAIN_CYCLES + 1);
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(RETRAIN_CYCLES - 1);

    logic [RT_W-1:0] retrain_q, retrain_d;

    assign auto_start = (state_q == S_DONE) && (retrain_q == RT_LAST);

    // Counts only while idling in DONE; any restart clears it.
    always_comb begin
        retrain_d = '0;
        if (state_q == S_DONE && !start && !auto_start)
            retrain_d = retrain_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retrain_q <= '0;
        else     retrain_q <= retrain_d;
    end
`else
    assign auto_start = 1'b0;
`endif

    assign go = start | auto_start;

    always_comb begin
        rx_bit = 1'b0;
        for (int i = 0; i < LANES; i++)
            if (lane_q == LANE_W'(i)) rx_bit = rx_sample[i];
    end

    always_comb begin
        center_ok  = (best_len_q >= MIN_LEN);
        center_tap = center_ok ? (best_start_q + TAP_W'(best_len_q >> 1)) : MID_TAP;
    end

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        tap_d        = tap_q;
        cnt_d        = cnt_q;
        ref_d        = ref_q;
        fail_d       = fail_q;
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        tap_out_d    = tap_out_q;
        tap_load_d   = '0;
        busy_d       = busy_q;
        done_d       = done_q;
        lane_ok_d    = lane_ok_q;
        eye_width_d  = eye_width_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d      = S_SET_TAP;
                    lane_d       = '0;
                    tap_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    lane_ok_d    = '0;
                    eye_width_d  = '0;
                    cur_len_d    = '0;
                    cur_start_d  = '0;
                    best_len_d   = '0;
                    best_start_d = '0;
                end
            end
            S_SET_TAP: begin
                for (int i = 0; i < LANES; i++) begin
                    if (lane_q == LANE_W'(i)) begin
                        tap_out_d[i*TAP_W +: TAP_W] = tap_q;
                        tap_load_d[i]               = 1'b1;
                    end
                end
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                // Count 0 only captures the reference bit; counts 1..N compare.
                ref_d = rx_bit;
                if (cnt_q == '0)
                    fail_d = 1'b0;
                else if (rx_bit == ref_q)
                    fail_d = 1'b1;
                if (cnt_q == CHECK_LAST) state_d = S_EVAL;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            S_EVAL: begin
                if (!fail_q) begin
                    cur_len_d = cur_len_q + 1'b1;
                    if (cur_len_q == '0) cur_start_d = tap_q;
                end else begin
                    cur_len_d = '0;
                end
                if (cur_len_d > best_len_q) begin
                    best_len_d   = cur_len_d;
                    best_start_d = cur_start_d;
                end
                if (tap_q == LAST_TAP) begin
                    state_d = S_CENTER;
                end else begin
                    tap_d   = tap_q + 1'b1;
                    state_d = S_SET_TAP;
                end
            end
            S_CENTER: begin
                for (int i = 0; i < LANES; i++) begin
                    if (lane_q == LANE_W'(i)) begin
                        tap_out_d[i*TAP_W +: TAP_W]   = center_tap;
                        tap_load_d[i]                 = 1'b1;
                        lane_ok_d[i]                  = center_ok;
                        eye_width_d[i*LEN_W +: LEN_W] = best_len_q;
                    end
                end
                state_d = S_NEXT_LANE;
            end
            S_NEXT_LANE: begin
                if (lane_q == LAST_LANE) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    lane_d       = lane_q + 1'b1;
                    tap_d        = '0;
                    cur_len_d    = '0;
                    cur_start_d  = '0;
                    best_len_d   = '0;
                    best_start_d = '0;
                    state_d      = S_SET_TAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            tap_q        <= '0;
            cnt_q        <= '0;
            ref_q        <= 1'b0;
            fail_q       <= 1'b0;
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            tap_out_q    <= '0;
            tap_load_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            lane_ok_q    <= '0;
            eye_width_q  <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            tap_q        <= tap_d;
            cnt_q        <= cnt_d;
            ref_q        <= ref_d;
            fail_q       <= fail_d;
            cur_len_q    <= cur_len_d;
            cur_start_q  <= cur_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            tap_out_q    <= tap_out_d;
            tap_load_q   <= tap_load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            lane_ok_q    <= lane_ok_d;
            eye_width_q  <= eye_width_d;
        end
    end

    assign tap_out   = tap_out_q;
    assign tap_load  = tap_load_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign lane_ok   = lane_ok_q;
    assign eye_width = eye_width_q;

endmodule
`default_nettype wire

// File: doc/dpa_lane_align.md
Name: dpa_lane_align

Overview:
- Parametrised per-lane dynamic phase alignment calibrator for the RGMII receive path; generalises single-lane DPA to LANES independent lanes (default 4 rxd + 1 rx_ctl).
- Sweeps each lane's input-delay tap across 0..NTAPS-1 while the link sends a 1010 toggle training pattern, then finds the longest passing window per lane.
- Loads each lane's tap with the centre of that window.
- Sits between the IDELAY primitives (driven by tap_out/tap_load) and the RGMII receive sampler.

Parameters:
- LANES, 5, number of independently calibrated lanes.
- TAP_W, 5, width of one tap value.
- NTAPS, 32, number of taps swept, 2..2**TAP_W.
- SETTLE_CYCLES, 8, idle cycles after a tap load before checking begins.
- CHECK_CYCLES, 64, toggle comparisons required at one tap.
- MIN_EYE, 4, minimum passing-window width for a lane to be declared good.
- RETRAIN_CYCLES, 125000000, DONE-state interval before automatic recalibration (feature only).

Ports:
- clk  in  1  system clock (125 MHz RGMII domain).
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; begins calibration of all lanes; ignored while busy.
- rx_sample  in  LANES  per-lane sampled data after delay, synchronous to clk.
- tap_out  out  LANES*TAP_W  current tap per lane; lane i occupies [i*TAP_W +: TAP_W].
- tap_load  out  LANES  one-cycle pulse per lane when its tap_out slice changes.
- busy  out  1  high from the accepted start until DONE.
- done  out  1  high in DONE; cleared on the next accepted start.
- lane_ok  out  LANES  bit i set if lane i's best window >= MIN_EYE; valid when done.
- eye_width  out  LANES*(TAP_W+1)  best window length per lane; valid when done.

Behaviour:
- Reset values: tap_out=0, tap_load=0, busy=0, done=0, lane_ok=0, eye_width=0; FSM in IDLE.
- Reset mid-sweep aborts immediately. Taps return to 0; no tap_load is issued.
- FSM states:
  - IDLE: on start -> SET_TAP with lane=0, tap=0; busy=1; per-lane window registers cleared.
  - SET_TAP: write tap to the current lane slice; pulse tap_load[lane] for 1 cycle; -> SETTLE.
  - SETTLE: count SETTLE_CYCLES -> CHECK.
  - CHECK:
    - The first cycle captures the reference bit.
    - Each following cycle requires rx_sample[lane] != previous bit.
    - Any equal pair sets fail.
    - After CHECK_CYCLES comparisons -> EVAL. An early fail does not shorten CHECK.
  - EVAL:
    - Pass: cur_len++; on a 0->pass transition, cur_start=tap.
    - Fail: cur_len=0.
    - If updated cur_len > best_len (strictly), copy cur_start/cur_len to best. Ties keep the earliest window.
    - If tap==NTAPS-1 -> CENTER, else tap++ -> SET_TAP.
  - CENTER:
    - Pass (best_len >= MIN_EYE): final tap = best_start + (best_len>>1), floor; lane_ok set.
    - Fail (best_len < MIN_EYE): final tap = NTAPS/2; lane_ok cleared.
    - eye_width = best_len. Load the final tap and pulse tap_load.
    - -> NEXT_LANE.
  - NEXT_LANE: lane==LANES-1 -> DONE, else lane++, clear window registers -> SET_TAP at tap 0.
  - DONE: busy=0, done=1; start -> IDLE behaviour (restarts calibration).
- A window ending at NTAPS-1 closes at the sweep end; no wrap-around to tap 0.
- Only the lane under calibration changes tap; other lanes hold their value.
- Per-tap latency is 1+SETTLE_CYCLES+1+CHECK_CYCLES+1 cycles; full calibration takes LANES*NTAPS of those plus CENTER/NEXT_LANE overhead.
- start coincident with rst: rst wins.

Optional Feature:
- DPA_RETRAIN_EN defined:
  - A counter runs in DONE; after RETRAIN_CYCLES it self-starts a recalibration (same as start).
  - done drops and busy rises during recalibration. Counter is cleared by a manual start.
- Not defined: DONE persists until an external start; no counter logic is synthesised.

Test Plan:
- Lane 0 passes taps 10..19, others fail all taps -> tap_out lane0=15, lane_ok=5'b00001, eye_width lane0=10, other lanes tap=16, eye_width=0.
- Two windows on lane 2, taps 3..8 (6) and 20..25 (6) -> tie keeps first: tap=6, eye_width=6.
- Window 28..31 touching the top of sweep -> tap=30, eye_width=4, lane_ok set (MIN_EYE=4); window 28..30 -> width 3, tap=16, lane_ok clear.
- Assert rst during lane 3 CHECK -> all outputs 0 asynchronously; a new start yields a full recalibration with no stale window data.
- start pulsed while busy ignored; start in DONE clears done within 1 cycle and re-sweeps lane 0 from tap 0, checking tap_load pulse count = LANES*(NTAPS+1).
- DPA_RETRAIN_EN with RETRAIN_CYCLES=1000 -> busy rises exactly 1000 cycles after done, with no external start.
